// File: rtl/vram_pkg.sv
// Shared definitions for the VRAM user-port arbiter.
//   VRAM_ADDR_W / VRAM_DATA_W : default geometry of the VRAM user port.
//   ST_IDLE / ST_OWN0 / ST_OWN1 : arbiter state encoding.
//   req_id_t                  : requester identifier (0 = host bridge, 1 = fill/copy engine).
package vram_pkg;

  localparam int VRAM_ADDR_W = 15;
  localparam int VRAM_DATA_W = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN0 = 2'd1;
  localparam logic [1:0] ST_OWN1 = 2'd2;

  typedef logic req_id_t;

  // Ownership state that belongs to a given requester.
  function automatic logic [1:0] own_state(input req_id_t id);
    return id ? ST_OWN1 : ST_OWN0;
  endfunction

endpackage

// File: rtl/vram_port_arbiter_if.sv
// Bundle of all requester-side and VRAM-side signals of the arbiter.
//   req/we/addr/wdata 0,1 : requester transfer requests
//   gnt/rdata/rvalid 0,1  : grants and read responses back to requesters
//   vram_addr/wdata/we    : drive toward the VRAM user port
//   vram_rdata            : VRAM read data (1-cycle synchronous read)
//   busy                  : any grant active
// Modports: slave = the arbiter, master = requesters plus VRAM.
interface vram_port_arbiter_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 8
);

  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              gnt0;
  logic              gnt1;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic              rvalid0;
  logic              rvalid1;
  logic [ADDR_W-1:0] vram_addr;
  logic [DATA_W-1:0] vram_wdata;
  logic              vram_we;
  logic [DATA_W-1:0] vram_rdata;
  logic              busy;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, vram_rdata,
    output gnt0, gnt1, rdata0, rdata1, rvalid0, rvalid1,
           vram_addr, vram_wdata, vram_we, busy
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, vram_rdata,
    input  gnt0, gnt1, rdata0, rdata1, rvalid0, rvalid1,
           vram_addr, vram_wdata, vram_we, busy
  );

endinterface

// File: rtl/vram_port_arbiter_rr_tenure_ctr.sv
// Tenure counter for the current grant owner.
//   clk, rst : clock, synchronous active-high reset
//   clr      : owner changes this cycle; restart the count
//   inc      : a transfer is accepted this cycle
//   hit_max  : the count is at MAX_BURST after this cycle's acceptance
// The count saturates at MAX_BURST so an uncontested owner never wraps.
module rr_tenure_ctr #(
  parameter int MAX_BURST = 16,
  parameter int CNT_W     = $clog2(MAX_BURST + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic hit_max
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             at_max;

  assign at_max = (cnt_q == CNT_MAX);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !at_max) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Looks one acceptance ahead so the owner can hand over on the cycle
  // right after its last allowed transfer.
  assign hit_max = at_max || (inc && (cnt_q == CNT_LAST));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/vram_port_arbiter.sv
// Two-requester arbiter in front of a single-port synchronous VRAM.
//   clk, rst : user-side clock, synchronous active-high reset
//   bus      : vram_port_arbiter_if.slave
//              - req/we/addr/wdata 0,1 in; gnt/rdata/rvalid 0,1 out
//              - vram_addr/vram_wdata/vram_we out, vram_rdata in
//              - busy out
// Requester 0 is the host bus bridge, requester 1 the fill/copy engine.
// A grant tenure lasts while the owner keeps requesting; a waiting
// requester takes over after MAX_BURST accepted transfers. Reads return
// one cycle later, routed by a registered tag rather than by the grant.
module vram_port_arbiter
  import vram_pkg::*;
#(
  parameter int ADDR_W    = VRAM_ADDR_W,
  parameter int DATA_W    = VRAM_DATA_W,
  parameter int MAX_BURST = 16
) (
  input logic                clk,
  input logic                rst,
  vram_port_arbiter_if.slave bus
);

  logic [1:0]        state_q;
  logic [1:0]        state_d;
  logic              last_owner_q;
  logic              last_owner_d;
  logic              rd_pend_q;
  logic              rd_pend_d;
  req_id_t           rd_tag_q;
  req_id_t           rd_tag_d;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata0_d;
  logic [DATA_W-1:0] rdata1_q;
  logic [DATA_W-1:0] rdata1_d;

  req_id_t           owner;
  logic              own_active;
  logic              req_own;
  logic              req_oth;
  logic              we_own;
  logic              accept;
  logic              enter;
  logic              hit_max;
  logic              rvalid0;
  logic              rvalid1;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // Owner view: which requester holds the port and what it is asking for.
  assign own_active = (state_q != ST_IDLE);
  assign owner      = (state_q == ST_OWN1);
  assign req_own    = owner ? bus.req1 : bus.req0;
  assign req_oth    = owner ? bus.req0 : bus.req1;
  assign we_own     = owner ? bus.we1  : bus.we0;

  // No transfer is taken while reset is held, so VRAM is never written
  // and no read response is queued during reset.
  assign accept = own_active && req_own && !rst;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req0 && !bus.req1) begin
          state_d = ST_OWN0;
        end else if (bus.req1 && !bus.req0) begin
          state_d = ST_OWN1;
        end else if (bus.req0 && bus.req1) begin
          // Tie goes to whoever did not own the port most recently.
          state_d = last_owner_q ? ST_OWN0 : ST_OWN1;
        end
      end
      ST_OWN0, ST_OWN1: begin
        if (!req_own) begin
          state_d = req_oth ? own_state(!owner) : ST_IDLE;
        end else if (req_oth && hit_max) begin
          state_d = own_state(!owner);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Any arrival in an ownership state (from IDLE or a direct hand-over).
  assign enter        = (state_d != state_q) && (state_d != ST_IDLE);
  assign last_owner_d = enter ? (state_d == ST_OWN1) : last_owner_q;

  rr_tenure_ctr #(
    .MAX_BURST (MAX_BURST)
  ) u_tenure (
    .clk     (clk),
    .rst     (rst),
    .clr     (enter),
    .inc     (accept),
    .hit_max (hit_max)
  );

  // Read response tracking: one outstanding read at most, since VRAM
  // latency is exactly one cycle.
  assign rd_pend_d = accept && !we_own;
  assign rd_tag_d  = owner;

  assign rvalid0 = rd_pend_q && !rd_tag_q;
  assign rvalid1 = rd_pend_q &&  rd_tag_q;

  // Read data is passed straight through on the response cycle and then
  // held from the capture register until the next response.
  always_comb begin
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    if (rvalid0) begin
      rdata0_d = bus.vram_rdata;
    end
    if (rvalid1) begin
      rdata1_d = bus.vram_rdata;
    end
  end

  // VRAM drive follows the granted requester; zero when idle.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    if (own_active) begin
      sel_addr  = owner ? bus.addr1  : bus.addr0;
      sel_wdata = owner ? bus.wdata1 : bus.wdata0;
    end
  end

  assign bus.vram_addr  = sel_addr;
  assign bus.vram_wdata = sel_wdata;
  assign bus.vram_we    = accept && we_own;

  assign bus.gnt0    = (state_q == ST_OWN0);
  assign bus.gnt1    = (state_q == ST_OWN1);
  assign bus.busy    = own_active;
  assign bus.rvalid0 = rvalid0;
  assign bus.rvalid1 = rvalid1;
  assign bus.rdata0  = rdata0_d;
  assign bus.rdata1  = rdata1_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_owner_q <= 1'b1;
      rd_pend_q    <= 1'b0;
      rd_tag_q     <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      rd_pend_q    <= rd_pend_d;
      rd_tag_q     <= rd_tag_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

endmodule
